lsu_ctrl: RTL and testbench

//  Load/store unit between the execute stage and the data-memory stage.
//  - Takes one load/store request per handshake from execute.
//  - Checks alignment and funct3, then drives word-aligned accesses with byte enables.
//  - Waits out the memory read latency.
//  - Returns the extracted, sign- or zero-extended load result to writeback with
//    rsp_valid. Stalls execute (req_ready low) while an access is in flight.

---
 rtl/lsu_ctrl.sv | 272 +++++++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl -- load/store unit between execute and the data-memory stage.
//
// Accepts one RV32I load/store per handshake, validates funct3 and alignment,
// issues a single word-aligned memory access with byte enables, waits out the
// memory read latency and returns the extracted, extended load result.
// Execute is stalled (req_ready low) from the accept until the response cycle
// has passed.
//
// Parameters
//   MEM_LAT     data-memory read latency in cycles (1..4)
//
// Ports
//   clk, rst    clock (rising edge) and synchronous active-high reset
//   req_*       request from execute: valid/ready handshake, we (1 = store),
//               funct3, byte address, store data, load destination register
//   mem_*       data-memory side: one-cycle strobe mem_en, direction mem_dmem
//               (1 read, 0 write), byte enables, word address, lane-replicated
//               store data, read data returned MEM_LAT cycles after mem_en
//   rsp_*       one-cycle completion pulse to writeback with load data,
//               destination register and an error flag (misaligned/illegal)
// -----------------------------------------------------------------------------
module lsu_ctrl #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  // execute side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  // data-memory side
  output logic        mem_en,
  output logic        mem_dmem,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  // writeback side
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // WAIT counts down from MEM_LAT-1; the cycle in which it reads 0 is the
  // last WAIT cycle, and mem_rdata is captured on the edge that ends it.
  localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

  state_t      state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;

  // Request fields that are still needed after the accept edge.
  logic        we_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  off_reg;
  logic [4:0]  rd_reg;

  // Registered outputs.
  logic        mem_en_reg,    mem_en_next;
  logic        mem_dmem_reg,  mem_dmem_next;
  logic [3:0]  mem_be_reg,    mem_be_next;
  logic [31:0] mem_addr_reg,  mem_addr_next;
  logic [31:0] mem_wdata_reg, mem_wdata_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic [31:0] rsp_data_reg,  rsp_data_next;
  logic [4:0]  rsp_rd_reg,    rsp_rd_next;
  logic        rsp_err_reg,   rsp_err_next;

  logic        accept;
  logic        f3_legal;
  logic        misaligned;
  logic        req_err;
  logic        last_wait;

  // ---------------------------------------------------------------------------
  // Request decode (combinational, from the live request)
  // ---------------------------------------------------------------------------
  always_comb begin
    f3_legal = 1'b0;
    if (req_we) begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
        default:                f3_legal = 1'b0;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
        default:                                f3_legal = 1'b0;
      endcase
    end
  end

  // funct3[1:0] encodes the access size for both loads and stores.
  always_comb begin
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign req_err = !f3_legal || misaligned;

  // Per-lane store byte enables and replicated store data. Only consulted for
  // legal stores, so the size-10 (word) arm doubles as the default.
  logic [3:0]  be_dec;
  logic [31:0] wdata_dec;
  logic [7:0]  rd_lane [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);

    assign be_dec[gi] = (req_funct3[1:0] == 2'b00) ? (req_addr[1:0] == LANE) :
                        (req_funct3[1:0] == 2'b01) ? (req_addr[1] == LANE[1]) :
                                                     1'b1;

    assign wdata_dec[8*gi +: 8] =
        (req_funct3[1:0] == 2'b00) ? req_wdata[7:0] :
        (req_funct3[1:0] == 2'b01) ? req_wdata[8*(gi%2) +: 8] :
                                     req_wdata[8*gi +: 8];

    assign rd_lane[gi] = mem_rdata[8*gi +: 8];
  end

  // ---------------------------------------------------------------------------
  // Load extraction from the returned word, using the captured request.
  // ---------------------------------------------------------------------------
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    ld_byte = rd_lane[off_reg];
    ld_half = off_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_reg)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: next state plus next values of every registered output.
  // ---------------------------------------------------------------------------
  assign last_wait = (state_reg == S_WAIT) && (cnt_reg == 2'd0);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    accept         = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          state_next = req_err ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_next = we_reg ? S_RESP : S_WAIT;
        cnt_next   = CNT_INIT;
      end
      S_WAIT: begin
        if (cnt_reg == 2'd0) begin
          state_next = S_RESP;
        end else begin
          cnt_next = cnt_reg - 2'd1;
        end
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // The memory strobe and its qualifiers are only non-idle for the single
    // ISSUE cycle, which is exactly the cycle after a clean accept.
    mem_en_next    = accept && !req_err;
    mem_dmem_next  = !(accept && !req_err && req_we);
    mem_be_next    = (accept && !req_err && req_we) ? be_dec    : 4'd0;
    mem_wdata_next = (accept && !req_err && req_we) ? wdata_dec : 32'd0;
    mem_addr_next  = accept ? {req_addr[31:2], 2'b00} : mem_addr_reg;

    // Response fields are zero everywhere except the RESP cycle; stores and
    // errors leave data and rd at zero.
    rsp_valid_next = (state_next == S_RESP);
    rsp_err_next   = accept && req_err;
    rsp_data_next  = last_wait ? ld_data : 32'd0;
    rsp_rd_next    = last_wait ? rd_reg  : 5'd0;
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Captured request and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg        <= 1'b0;
      funct3_reg    <= 3'd0;
      off_reg       <= 2'd0;
      rd_reg        <= 5'd0;
      mem_en_reg    <= 1'b0;
      mem_dmem_reg  <= 1'b1;
      mem_be_reg    <= 4'd0;
      mem_addr_reg  <= 32'd0;
      mem_wdata_reg <= 32'd0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= 32'd0;
      rsp_rd_reg    <= 5'd0;
      rsp_err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        we_reg     <= req_we;
        funct3_reg <= req_funct3;
        off_reg    <= req_addr[1:0];
        rd_reg     <= req_rd;
      end
      mem_en_reg    <= mem_en_next;
      mem_dmem_reg  <= mem_dmem_next;
      mem_be_reg    <= mem_be_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_rd_reg    <= rsp_rd_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  // req_ready is decoded from state and forced low while reset is asserted.
  assign req_ready = (state_reg == S_IDLE) && !rst;

  assign mem_en    = mem_en_reg;
  assign mem_dmem  = mem_dmem_reg;
  assign mem_be    = mem_be_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_rd    = rsp_rd_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl -- self-checking bench for lsu_ctrl.
//
// Two instances run side by side on shared request inputs, one with a memory
// latency of 1 and one with 3. Each transaction is observed for a fixed window
// after its accept edge and compared per instance against expected strobes,
// byte enables, store data, response timing and load results.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] mem_rdata;

  logic [1:0]  req_ready_w, mem_en_w, mem_dmem_w, rsp_valid_w, rsp_err_w;
  logic [3:0]  mem_be_w    [2];
  logic [31:0] mem_addr_w  [2];
  logic [31:0] mem_wdata_w [2];
  logic [31:0] rsp_data_w  [2];
  logic [4:0]  rsp_rd_w    [2];

  int errors = 0;
  int checks = 0;
  int lat [2] = '{1, 3};

  always #5 clk = ~clk;

  lsu_ctrl #(.MEM_LAT(1)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready_w[0]), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_en(mem_en_w[0]), .mem_dmem(mem_dmem_w[0]), .mem_be(mem_be_w[0]),
    .mem_addr(mem_addr_w[0]), .mem_wdata(mem_wdata_w[0]), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid_w[0]), .rsp_data(rsp_data_w[0]), .rsp_rd(rsp_rd_w[0]),
    .rsp_err(rsp_err_w[0])
  );

  lsu_ctrl #(.MEM_LAT(3)) u_dut_l3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready_w[1]), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_en(mem_en_w[1]), .mem_dmem(mem_dmem_w[1]), .mem_be(mem_be_w[1]),
    .mem_addr(mem_addr_w[1]), .mem_wdata(mem_wdata_w[1]), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid_w[1]), .rsp_data(rsp_data_w[1]), .rsp_rd(rsp_rd_w[1]),
    .rsp_err(rsp_err_w[1])
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    // expected
    logic        err;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] data;
    logic [4:0]  rdo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: derived from access size, byte offset and plain
  // arithmetic (shift, modulo, multiply-to-replicate, subtract-to-sign-extend).
  function automatic vec_t model(input vec_t v);
    vec_t   r;
    int     off;
    int     size;
    bit     legal;
    longint val;
    longint lim;
    r     = v;
    off   = int'(v.addr % 4);
    size  = 1 << (v.f3 % 4);
    legal = v.we ? (v.f3 <= 2) : (v.f3 != 3 && v.f3 <= 5);
    r.err  = !legal || ((off % size) != 0);
    r.be   = 4'd0;
    r.wd   = 32'd0;
    r.data = 32'd0;
    r.rdo  = 5'd0;
    if (!r.err) begin
      if (v.we) begin
        r.be = 4'(((1 << size) - 1) << off);
        if (size == 1)      r.wd = (v.wdata % 256) * 32'h01010101;
        else if (size == 2) r.wd = (v.wdata % 65536) * 32'h00010001;
        else                r.wd = v.wdata;
      end else begin
        lim = longint'(1) << (8 * size);
        val = (longint'(v.rdata) >> (8 * off)) % lim;
        if (v.f3 < 4 && size < 4 && val >= lim / 2) val = val - lim;
        r.data = 32'(val);
        r.rdo  = v.rd;
      end
    end
    return r;
  endfunction

  // Drive one request, let both instances accept it on the same edge, then
  // observe cycles 1..7 after the accept edge and compare.
  task automatic run_txn(input vec_t v, input string tag);
    int          en_cnt [2];
    int          en_cyc [2];
    int          rsp_cnt [2];
    int          rsp_cyc [2];
    int          ready_bad [2];
    int          idle_bad [2];
    logic [31:0] a_addr [2];
    logic [31:0] a_wd [2];
    logic [31:0] a_data [2];
    logic [3:0]  a_be [2];
    logic        a_dmem [2];
    logic        a_err [2];
    logic [4:0]  a_rd [2];
    int          exp_cyc [2];

    for (int d = 0; d < 2; d++) begin
      en_cnt[d] = 0; en_cyc[d] = 0; rsp_cnt[d] = 0; rsp_cyc[d] = 0;
      ready_bad[d] = 0; idle_bad[d] = 0;
      a_addr[d] = 0; a_wd[d] = 0; a_data[d] = 0; a_be[d] = 0;
      a_dmem[d] = 1'b1; a_err[d] = 1'b0; a_rd[d] = 0;
      exp_cyc[d] = v.err ? 1 : (v.we ? 2 : 2 + lat[d]);
    end

    @(negedge clk);
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    req_rd     = v.rd;
    mem_rdata  = v.rdata;
    req_valid  = 1'b1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("%s d%0d ready_at_req", tag, d), 32'(req_ready_w[d]), 32'd1);

    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // scramble request inputs so only captured values can be used
        req_valid  = 1'b0;
        req_addr   = ~v.addr;
        req_wdata  = ~v.wdata;
        req_rd     = ~v.rd;
        req_funct3 = ~v.f3;
        req_we     = ~v.we;
      end
      for (int d = 0; d < 2; d++) begin
        if (mem_en_w[d]) begin
          en_cnt[d]++;
          en_cyc[d] = c;
          a_addr[d] = mem_addr_w[d];
          a_be[d]   = mem_be_w[d];
          a_wd[d]   = mem_wdata_w[d];
          a_dmem[d] = mem_dmem_w[d];
        end else if (mem_dmem_w[d] !== 1'b1 || mem_be_w[d] !== 4'd0 || mem_wdata_w[d] !== 32'd0) begin
          idle_bad[d]++;
        end
        if (rsp_valid_w[d]) begin
          rsp_cnt[d]++;
          rsp_cyc[d] = c;
          a_data[d]  = rsp_data_w[d];
          a_rd[d]    = rsp_rd_w[d];
          a_err[d]   = rsp_err_w[d];
        end
        if (c <= exp_cyc[d] && req_ready_w[d] !== 1'b0) ready_bad[d]++;
        if (c == exp_cyc[d] + 1 && req_ready_w[d] !== 1'b1) ready_bad[d]++;
      end
    end

    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s d%0d mem_en_count", tag, d), 32'(en_cnt[d]), v.err ? 32'd0 : 32'd1);
      if (!v.err) begin
        chk($sformatf("%s d%0d mem_en_cycle", tag, d), 32'(en_cyc[d]), 32'd1);
        chk($sformatf("%s d%0d mem_addr", tag, d), a_addr[d], {v.addr[31:2], 2'b00});
        chk($sformatf("%s d%0d mem_be", tag, d), 32'(a_be[d]), 32'(v.be));
        chk($sformatf("%s d%0d mem_wdata", tag, d), a_wd[d], v.wd);
        chk($sformatf("%s d%0d mem_dmem", tag, d), 32'(a_dmem[d]), 32'(!v.we));
      end
      chk($sformatf("%s d%0d rsp_count", tag, d), 32'(rsp_cnt[d]), 32'd1);
      chk($sformatf("%s d%0d rsp_cycle", tag, d), 32'(rsp_cyc[d]), 32'(exp_cyc[d]));
      chk($sformatf("%s d%0d rsp_data", tag, d), a_data[d], v.data);
      chk($sformatf("%s d%0d rsp_rd", tag, d), 32'(a_rd[d]), 32'(v.rdo));
      chk($sformatf("%s d%0d rsp_err", tag, d), 32'(a_err[d]), 32'(v.err));
      chk($sformatf("%s d%0d ready_window", tag, d), 32'(ready_bad[d]), 32'd0);
      chk($sformatf("%s d%0d idle_outputs", tag, d), 32'(idle_bad[d]), 32'd0);
    end
    $display("txn %s we=%0d f3=%0d addr=%h wdata=%h rdata=%h -> err=%0d be=%b wd=%h data=%h rd=%0d",
             tag, v.we, v.f3, v.addr, v.wdata, v.rdata, v.err, v.be, v.wd, v.data, v.rdo);
  endtask

  vec_t tbl [14];

  initial begin
    int   bad;
    int   rc;
    int   rcyc;
    vec_t rv;

    // we, f3, addr, wdata, rdata, rd | err, be, wd, data, rdo
    tbl[0]  = '{1'b1, 3'b000, 32'h103, 32'h000000AB, 32'h0,        5'd5,  1'b0, 4'b1000, 32'hABABABAB, 32'h0,        5'd0};
    tbl[1]  = '{1'b0, 3'b000, 32'h102, 32'h0,        32'h12F45678, 5'd7,  1'b0, 4'b0000, 32'h0,        32'hFFFFFFF4, 5'd7};
    tbl[2]  = '{1'b0, 3'b100, 32'h102, 32'h0,        32'h12F45678, 5'd7,  1'b0, 4'b0000, 32'h0,        32'h000000F4, 5'd7};
    tbl[3]  = '{1'b0, 3'b001, 32'h101, 32'h0,        32'h12F45678, 5'd9,  1'b1, 4'b0000, 32'h0,        32'h0,        5'd0};
    tbl[4]  = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h12F45678, 5'd9,  1'b1, 4'b0000, 32'h0,        32'h0,        5'd0};
    tbl[5]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h80017FFF, 5'd3,  1'b0, 4'b0000, 32'h0,        32'hFFFF8001, 5'd3};
    tbl[6]  = '{1'b0, 3'b101, 32'h100, 32'h0,        32'h8001F00D, 5'd4,  1'b0, 4'b0000, 32'h0,        32'h0000F00D, 5'd4};
    tbl[7]  = '{1'b0, 3'b010, 32'h104, 32'h0,        32'hDEADBEEF, 5'd31, 1'b0, 4'b0000, 32'h0,        32'hDEADBEEF, 5'd31};
    tbl[8]  = '{1'b1, 3'b001, 32'h10A, 32'h1234ABCD, 32'h0,        5'd2,  1'b0, 4'b1100, 32'hABCDABCD, 32'h0,        5'd0};
    tbl[9]  = '{1'b1, 3'b010, 32'h10C, 32'hCAFEF00D, 32'h0,        5'd2,  1'b0, 4'b1111, 32'hCAFEF00D, 32'h0,        5'd0};
    tbl[10] = '{1'b1, 3'b010, 32'h10E, 32'hCAFEF00D, 32'h0,        5'd2,  1'b1, 4'b0000, 32'h0,        32'h0,        5'd0};
    tbl[11] = '{1'b1, 3'b100, 32'h110, 32'h00000011, 32'h0,        5'd2,  1'b1, 4'b0000, 32'h0,        32'h0,        5'd0};
    tbl[12] = '{1'b0, 3'b000, 32'h100, 32'h0,        32'h0000007F, 5'd1,  1'b0, 4'b0000, 32'h0,        32'h0000007F, 5'd1};
    tbl[13] = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h80000000, 5'd6,  1'b0, 4'b0000, 32'h0,        32'hFFFFFF80, 5'd6};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_rd     = 5'd0;
    mem_rdata  = 32'd0;

    // Reset: two cycles high, then release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk($sformatf("reset d%0d ready_in_rst", d), 32'(req_ready_w[d]), 32'd0);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset d%0d req_ready", d), 32'(req_ready_w[d]), 32'd1);
      chk($sformatf("reset d%0d mem_en", d), 32'(mem_en_w[d]), 32'd0);
      chk($sformatf("reset d%0d rsp_valid", d), 32'(rsp_valid_w[d]), 32'd0);
      chk($sformatf("reset d%0d mem_dmem", d), 32'(mem_dmem_w[d]), 32'd1);
      chk($sformatf("reset d%0d mem_be", d), 32'(mem_be_w[d]), 32'd0);
      chk($sformatf("reset d%0d rsp_data", d), rsp_data_w[d], 32'd0);
    end

    // Directed vector table.
    for (int i = 0; i < 14; i++)
      run_txn(tbl[i], $sformatf("vec%0d", i));

    // Randomized requests checked against the reference model.
    for (int i = 0; i < 80; i++) begin
      rv.we    = 1'($urandom_range(0, 1));
      rv.f3    = 3'($urandom_range(0, 7));
      rv.addr  = $urandom;
      rv.wdata = $urandom;
      rv.rdata = $urandom;
      rv.rd    = 5'($urandom_range(0, 31));
      rv       = model(rv);
      run_txn(rv, $sformatf("rnd%0d", i));
    end

    // req_valid held high on the latency-3 instance: response in cycle 5,
    // stalled cycles 1..5, second accept only at the end of cycle 6.
    @(negedge clk);
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h200;
    req_rd     = 5'd12;
    mem_rdata  = 32'h0BADF00D;
    req_valid  = 1'b1;
    bad  = 0;
    rc   = 0;
    rcyc = 0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c <= 5 && req_ready_w[1] !== 1'b0) bad++;
      if (c >= 2 && c <= 6 && mem_en_w[1] !== 1'b0) bad++;
      if (c == 6) chk("held d1 ready_c6", 32'(req_ready_w[1]), 32'd1);
      if (rsp_valid_w[1]) begin
        rc++;
        rcyc = c;
        chk("held d1 rsp_data", rsp_data_w[1], 32'h0BADF00D);
        chk("held d1 rsp_rd", 32'(rsp_rd_w[1]), 32'd12);
      end
      if (c == 7) begin
        chk("held d1 second_accept", 32'(mem_en_w[1]), 32'd1);
        req_valid = 1'b0;
      end
    end
    chk("held d1 stall_window", 32'(bad), 32'd0);
    chk("held d1 rsp_count", 32'(rc), 32'd1);
    chk("held d1 rsp_cycle", 32'(rcyc), 32'd5);
    $display("txn held LW addr=00000200 on latency-3 instance, rsp cycle %0d", rcyc);
    repeat (10) @(negedge clk);

    // Reset pulse while both instances sit in WAIT: the access is abandoned.
    @(negedge clk);
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h300;
    req_rd     = 5'd8;
    mem_rdata  = 32'h55AA55AA;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("abort d%0d req_ready", d), 32'(req_ready_w[d]), 32'd1);
      chk($sformatf("abort d%0d mem_en", d), 32'(mem_en_w[d]), 32'd0);
      chk($sformatf("abort d%0d rsp_valid", d), 32'(rsp_valid_w[d]), 32'd0);
    end
    bad = 0;
    for (int c = 4; c <= 9; c++) begin
      @(negedge clk);
      if (rsp_valid_w !== 2'b00 || mem_en_w !== 2'b00) bad++;
    end
    chk("abort quiet_after_rst", 32'(bad), 32'd0);
    $display("txn abort LW addr=00000300 reset during WAIT");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
